// File: rtl/enc_mes_gearbox.sv
// Symbol-granular FIFO gearbox between the message generator and the encoder datapath.
// Takes IN_SYM symbols per beat, emits OUT_SYM per beat, and zero-pads and flags the final beat of a message.
module enc_mes_gearbox #(
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned IN_SYM  = 4,
    parameter int unsigned OUT_SYM = 3,
    parameter int unsigned DEP     = 12,
    parameter int unsigned CNT_W   = $clog2(DEP + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     con_stall,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_SYM*SYM_W-1:0]  in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_SYM*SYM_W-1:0] out_data,
    output logic [OUT_SYM-1:0]       out_keep,
    output logic                     out_last,
    output logic [CNT_W-1:0]         count
);

    localparam int unsigned BUF_W = DEP * SYM_W;
    localparam logic [CNT_W-1:0] L_IN   = CNT_W'(IN_SYM);
    localparam logic [CNT_W-1:0] L_OUT  = CNT_W'(OUT_SYM);
    localparam logic [CNT_W-1:0] L_DEP  = CNT_W'(DEP);
    localparam logic [CNT_W-1:0] L_ROOM = CNT_W'(DEP - IN_SYM);

    generate
        if (DEP < IN_SYM + OUT_SYM) begin : g_bad_dep
            $error("enc_mes_gearbox: DEP must be at least IN_SYM + OUT_SYM");
        end
    endgenerate

    // Symbol k of the store lives at bits [k*SYM_W +: SYM_W]; slot 0 is the oldest.
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_count;
    logic             r_last_pend;

    logic [BUF_W-1:0] w_buf_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_last_nxt;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_base;

    // Handshake and output fields decoded from held state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_keep  = '0;
        out_data  = r_buf[OUT_SYM*SYM_W-1:0];
        count     = r_count;

        in_ready  = !con_stall && !r_last_pend && (r_count <= L_ROOM);
        out_valid = !con_stall && ((r_count >= L_OUT) || (r_last_pend && (r_count != '0)));
        out_last  = r_last_pend && (r_count <= L_OUT) && (r_count != '0);
        for (int j = 0; j < int'(OUT_SYM); j++) begin
            out_keep[j] = (CNT_W'(j) < r_count);
        end
    end

    // Pop shifts the store down; a same-cycle push lands just above what survives the pop.
    always_comb begin
        w_push      = in_valid && in_ready;
        w_pop       = out_valid && out_ready;
        w_n         = '0;
        w_base      = '0;
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        w_last_nxt  = r_last_pend;

        if (w_pop) begin
            w_n = (r_count >= L_OUT) ? L_OUT : r_count;
        end
        w_base      = r_count - w_n;
        w_buf_nxt   = r_buf >> (SYM_W * 32'(w_n));
        w_count_nxt = w_base;

        if (w_push) begin
            w_buf_nxt   = w_buf_nxt | (BUF_W'(in_data) << (SYM_W * 32'(w_base)));
            w_count_nxt = w_base + L_IN;
        end

        if (w_pop && out_last) begin
            w_last_nxt = 1'b0;
        end
        if (w_push && in_last) begin
            w_last_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= '0;
            r_count     <= '0;
            r_last_pend <= 1'b0;
        end else begin
            r_buf       <= w_buf_nxt;
            r_count     <= w_count_nxt;
            r_last_pend <= w_last_nxt;
        end
    end

    a_count_le_dep : assert property (@(posedge clk) disable iff (rst) r_count <= L_DEP);

endmodule

// File: tb/tb_enc_mes_gearbox.sv
// Self-checking bench for enc_mes_gearbox: hand-derived vector table, directed corner sequences,
// and randomized traffic checked against a symbol-queue reference model.
module tb_enc_mes_gearbox;

    localparam int SYM_W   = 8;
    localparam int IN_SYM  = 4;
    localparam int OUT_SYM = 3;
    localparam int DEP     = 12;
    localparam int CNT_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     con_stall;
    logic                     in_valid;
    logic                     in_ready;
    logic [IN_SYM*SYM_W-1:0]  in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_SYM*SYM_W-1:0] out_data;
    logic [OUT_SYM-1:0]       out_keep;
    logic                     out_last;
    logic [CNT_W-1:0]         cnt;

    always #5 clk = ~clk;

    enc_mes_gearbox #(
        .SYM_W(SYM_W), .IN_SYM(IN_SYM), .OUT_SYM(OUT_SYM), .DEP(DEP)
    ) dut (
        .clk(clk), .rst(rst), .con_stall(con_stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .count(cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the stored message as an ordered list of symbols.
    int          q[$];
    bit          lp;
    bit          m_push, m_pop, m_last;
    logic [31:0] p_din;
    logic        p_il;

    typedef struct {
        logic        iv, il, ordy;
        logic [31:0] din;
        logic        ir, ov, last;
        logic [3:0]  cnt;
        logic [2:0]  keep;
        logic [23:0] data;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [23:0] pk3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic vec_t mk(input logic iv, input logic il, input logic ordy, input logic [31:0] din,
                                input logic ir, input logic ov, input logic last, input logic [3:0] c,
                                input logic [2:0] keep, input logic [23:0] data);
        vec_t v;
        v.iv = iv; v.il = il; v.ordy = ordy; v.din = din;
        v.ir = ir; v.ov = ov; v.last = last; v.cnt = c; v.keep = keep; v.data = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, then compare every output against the model.
    task automatic apply(input logic iv, input logic il, input logic ordy, input logic st,
                         input logic [31:0] din);
        int          sz;
        logic        e_ir, e_ov, e_last;
        logic [23:0] e_data;
        logic [2:0]  e_keep;
        in_valid  = iv;
        in_last   = il;
        out_ready = ordy;
        con_stall = st;
        in_data   = din;
        #2;
        sz     = q.size();
        e_ir   = !st && !lp && (DEP - sz >= IN_SYM);
        e_ov   = !st && ((sz >= OUT_SYM) || (lp && sz > 0));
        e_last = lp && (sz <= OUT_SYM) && (sz > 0);
        e_data = '0;
        e_keep = '0;
        for (int j = 0; j < OUT_SYM; j++) begin
            if (j < sz) begin
                e_data[j*SYM_W +: SYM_W] = 8'(q[j]);
                e_keep[j] = 1'b1;
            end
        end
        chk("in_ready",  32'(in_ready),  32'(e_ir));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("out_last",  32'(out_last),  32'(e_last));
        chk("out_keep",  32'(out_keep),  32'(e_keep));
        chk("out_data",  32'(out_data),  32'(e_data));
        chk("count",     32'(cnt),       32'(sz));
        m_push = iv && e_ir;
        m_pop  = e_ov && ordy;
        m_last = e_last;
        p_din  = din;
        p_il   = il;
    endtask

    // Clock edge, then apply the accepted transfers to the model.
    task automatic adv();
        int n;
        @(posedge clk);
        #1;
        if (m_pop) begin
            n = (q.size() < OUT_SYM) ? q.size() : OUT_SYM;
            repeat (n) void'(q.pop_front());
            if (m_last) lp = 1'b0;
        end
        if (m_push) begin
            for (int k = 0; k < IN_SYM; k++) q.push_back(int'(p_din[k*SYM_W +: SYM_W]));
            if (p_il) lp = 1'b1;
        end
    endtask

    task automatic cyc(input logic iv, input logic il, input logic ordy, input logic st,
                       input logic [31:0] din);
        apply(iv, il, ordy, st, din);
        adv();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; con_stall = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_data = '0;
        q.delete(); lp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",     32'(cnt),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_keep",  32'(out_keep),  32'd0);
        rst = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Stream of three beats, then a single partial message with in_last.
        tbl[0] = mk(1, 0, 1, pk4(1, 2, 3, 4),     1, 0, 0, 4'd0, 3'b000, 24'h0);
        tbl[1] = mk(1, 0, 1, pk4(5, 6, 7, 8),     1, 1, 0, 4'd4, 3'b111, pk3(1, 2, 3));
        tbl[2] = mk(1, 0, 1, pk4(9, 10, 11, 12),  1, 1, 0, 4'd5, 3'b111, pk3(4, 5, 6));
        tbl[3] = mk(0, 0, 1, 32'h0,               1, 1, 0, 4'd6, 3'b111, pk3(7, 8, 9));
        tbl[4] = mk(0, 0, 1, 32'h0,               1, 1, 0, 4'd3, 3'b111, pk3(10, 11, 12));
        tbl[5] = mk(0, 0, 1, 32'h0,               1, 0, 0, 4'd0, 3'b000, 24'h0);
        tbl[6] = mk(1, 1, 1, pk4(1, 2, 3, 4),     1, 0, 0, 4'd0, 3'b000, 24'h0);
        tbl[7] = mk(0, 0, 1, 32'h0,               0, 1, 0, 4'd4, 3'b111, pk3(1, 2, 3));
        tbl[8] = mk(0, 0, 1, 32'h0,               0, 1, 1, 4'd1, 3'b001, pk3(4, 0, 0));
        tbl[9] = mk(0, 0, 1, 32'h0,               1, 0, 0, 4'd0, 3'b000, 24'h0);
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].iv, tbl[i].il, tbl[i].ordy, 1'b0, tbl[i].din);
            chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("v%0d_out_last", i),  32'(out_last),  32'(tbl[i].last));
            chk($sformatf("v%0d_count", i),     32'(cnt),       32'(tbl[i].cnt));
            chk($sformatf("v%0d_out_keep", i),  32'(out_keep),  32'(tbl[i].keep));
            chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tbl[i].data));
            adv();
        end

        // Backpressure until full, then drain in order.
        cyc(1, 0, 0, 0, pk4(21, 22, 23, 24));
        cyc(1, 0, 0, 0, pk4(25, 26, 27, 28));
        cyc(1, 0, 0, 0, pk4(29, 30, 31, 32));
        apply(1, 0, 0, 0, pk4(33, 34, 35, 36));
        chk("full_count",    32'(cnt),      32'd12);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        adv();
        apply(0, 0, 1, 0, 32'h0);
        chk("drain0_data", 32'(out_data), 32'(pk3(21, 22, 23)));
        adv();
        apply(0, 0, 1, 0, 32'h0);
        chk("drain9_in_ready", 32'(in_ready), 32'd0);
        adv();
        apply(0, 0, 1, 0, 32'h0);
        chk("drain6_in_ready", 32'(in_ready), 32'd1);
        chk("drain6_data",     32'(out_data), 32'(pk3(27, 28, 29)));
        adv();
        cyc(0, 0, 1, 0, 32'h0);

        // Reach count=6, then push and pop in the same cycle.
        cyc(1, 0, 0, 0, pk4(41, 42, 43, 44));
        cyc(1, 0, 1, 0, pk4(45, 46, 47, 48));
        cyc(1, 0, 1, 0, pk4(49, 50, 51, 52));
        apply(1, 0, 1, 0, pk4(53, 54, 55, 56));
        chk("pp_count_before", 32'(cnt), 32'd6);
        adv();
        apply(0, 0, 0, 0, 32'h0);
        chk("pp_count_after", 32'(cnt),      32'd7);
        chk("pp_data_after",  32'(out_data), 32'(pk3(50, 51, 52)));
        adv();
        cyc(0, 0, 1, 0, 32'h0);
        cyc(0, 0, 1, 0, 32'h0);

        // Stall freezes everything, with one stranded symbol held.
        apply(1, 0, 1, 1, pk4(61, 62, 63, 64));
        chk("stall_in_ready",  32'(in_ready),  32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd0);
        chk("stall_count",     32'(cnt),       32'd1);
        chk("stall_data",      32'(out_data),  32'(pk3(56, 0, 0)));
        adv();
        apply(0, 0, 0, 0, 32'h0);
        chk("stall_held", 32'(cnt), 32'd1);
        adv();

        // Message ends mid-flight, then asynchronous reset between edges.
        cyc(1, 1, 1, 0, pk4(61, 62, 63, 64));
        cyc(0, 0, 1, 0, 32'h0);
        in_valid = 1'b0; out_ready = 1'b0; con_stall = 1'b0; in_last = 1'b0;
        #2;
        chk("pre_rst_out_last", 32'(out_last), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_count",     32'(cnt),       32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_last",  32'(out_last),  32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_out_keep",  32'(out_keep),  32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        q.delete(); lp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cyc(0, 0, 1, 0, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic        r_iv, r_il, r_or, r_st;
            logic [31:0] r_d;
            r_iv = 1'($urandom_range(0, 1));
            r_il = ($urandom_range(0, 4) == 0);
            r_or = ($urandom_range(0, 9) < 7);
            r_st = ($urandom_range(0, 9) == 0);
            r_d  = $urandom;
            cyc(r_iv, r_il, r_or, r_st, r_d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
